// File: rtl/delqa_rx_pkg.sv
// rtl/delqa_rx_pkg.sv - shared types and header layout for the receive frame writer
package delqa_rx_pkg;

    // SYNC re-aligns to a frame boundary after reset; FLUSH/HDR close out a stored frame.
    typedef enum logic [2:0] {
        SYNC,
        IDLE,
        RECV,
        FLUSH,
        HDR,
        DONE,
        DROP
    } rx_state_t;

    localparam int HDR_ERR     = 15;
    localparam int HDR_OVF     = 14;
    localparam int HDR_RUNT    = 13;
    localparam int HDR_LEN_MSB = 10;
    localparam int HDR_LEN_LSB = 0;

    localparam logic [9:0] HDR_ADR   = 10'd0;
    localparam logic [9:0] DATA_BASE = 10'd1;

    function automatic logic [15:0] make_hdr(input logic       err,
                                             input logic       ovf,
                                             input logic       runt,
                                             input logic [10:0] len);
        logic [15:0] h;
        h = '0;
        h[HDR_ERR]  = err;
        h[HDR_OVF]  = ovf;
        h[HDR_RUNT] = runt;
        h[HDR_LEN_MSB:HDR_LEN_LSB] = len;
        return h;
    endfunction

endpackage

// File: rtl/rx_frame_writer.sv
// rtl/rx_frame_writer.sv - packs MAC receive bytes into the 1K-word buffer and writes a frame header
//
// Ports:
//   eth_clk_i, eth_rst_n_i        clock, asynchronous active-low reset
//   rxd_vld_i/rxd_i/rxd_last_i    receive byte stream, rxd_last_i marks the final byte
//   rxd_err_i                     MAC error, sampled with every valid byte
//   own_i                         buffer owned by this block (firmware handshake)
//   eth_adr_o/eth_dat_o/eth_we_o  buffer write port, one word per strobe
//   done_o                        frame stored, header valid (level, held until own_i drops)
//   lost_o                        one-cycle pulse per dropped frame
module rx_frame_writer
    import delqa_rx_pkg::*;
#(
    parameter int MAXB = 1518,
    parameter int MINB = 60
) (
    input  logic        eth_clk_i,
    input  logic        eth_rst_n_i,
    input  logic        rxd_vld_i,
    input  logic [7:0]  rxd_i,
    input  logic        rxd_last_i,
    input  logic        rxd_err_i,
    input  logic        own_i,
    output logic [9:0]  eth_adr_o,
    output logic [15:0] eth_dat_o,
    output logic        eth_we_o,
    output logic        done_o,
    output logic        lost_o
);

    localparam logic [10:0] MAXB_W = 11'(MAXB);
    localparam logic [10:0] MINB_W = 11'(MINB);

    rx_state_t   state;
    logic [10:0] cnt;        // stored byte count, saturates at MAXB
    logic [7:0]  low;        // even byte waiting for its odd partner
    logic        err;
    logic        ovf;
    logic        from_done;  // current drop interrupted a completed frame
    logic [9:0]  word_adr;

    // Word holding byte index cnt; also the word of a pending low byte when cnt is odd.
    assign word_adr = DATA_BASE + cnt[10:1];

    always_ff @(posedge eth_clk_i or negedge eth_rst_n_i) begin
        if (!eth_rst_n_i) begin
            state     <= SYNC;
            cnt       <= '0;
            low       <= '0;
            err       <= 1'b0;
            ovf       <= 1'b0;
            from_done <= 1'b0;
            eth_adr_o <= '0;
            eth_dat_o <= '0;
            eth_we_o  <= 1'b0;
            done_o    <= 1'b0;
            lost_o    <= 1'b0;
        end else begin
            eth_we_o <= 1'b0;
            lost_o   <= 1'b0;
            case (state)
                // A gap means no frame is in flight; otherwise wait for the end of the cut frame.
                SYNC: begin
                    if (!rxd_vld_i || rxd_last_i) state <= IDLE;
                end

                IDLE, RECV: begin
                    if (!own_i) begin
                        if (state == RECV || rxd_vld_i) begin
                            lost_o    <= 1'b1;
                            from_done <= 1'b0;
                            cnt       <= '0;
                            err       <= 1'b0;
                            ovf       <= 1'b0;
                            state     <= (rxd_vld_i && rxd_last_i) ? IDLE : DROP;
                        end
                    end else if (rxd_vld_i) begin
                        state <= rxd_last_i ? FLUSH : RECV;
                        if (rxd_err_i) err <= 1'b1;
                        if (cnt < MAXB_W) begin
                            cnt <= cnt + 11'd1;
                            if (!cnt[0]) low <= rxd_i;
                            // Odd byte completes a word; an even last byte is written padded
                            // in the same cycle so the final data word lands at n+1.
                            if (cnt[0] || rxd_last_i) begin
                                eth_we_o  <= 1'b1;
                                eth_adr_o <= word_adr;
                                eth_dat_o <= cnt[0] ? {rxd_i, low} : {8'h00, rxd_i};
                            end
                        end else begin
                            ovf <= 1'b1;
                            if (rxd_last_i && cnt[0]) begin
                                eth_we_o  <= 1'b1;
                                eth_adr_o <= word_adr;
                                eth_dat_o <= {8'h00, low};
                            end
                        end
                    end
                end

                FLUSH: begin
                    eth_we_o  <= 1'b1;
                    eth_adr_o <= HDR_ADR;
                    eth_dat_o <= make_hdr(err, ovf, cnt < MINB_W, cnt);
                    state     <= HDR;
                end

                HDR: begin
                    done_o <= 1'b1;
                    cnt    <= '0;
                    err    <= 1'b0;
                    ovf    <= 1'b0;
                    state  <= DONE;
                end

                DONE: begin
                    if (rxd_vld_i) begin
                        lost_o    <= 1'b1;
                        from_done <= 1'b1;
                        done_o    <= own_i;
                        if (rxd_last_i) state <= own_i ? DONE : IDLE;
                        else            state <= DROP;
                    end else if (!own_i) begin
                        done_o <= 1'b0;
                        state  <= IDLE;
                    end
                end

                DROP: begin
                    if (!own_i) done_o <= 1'b0;
                    if (rxd_vld_i && rxd_last_i) state <= (from_done && own_i) ? DONE : IDLE;
                end

                default: state <= SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_rx_frame_writer.sv
// tb/tb_rx_frame_writer.sv - self-checking bench for rx_frame_writer
module tb_rx_frame_writer;

    localparam int MAXB = 1518;
    localparam int MINB = 60;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vld = 1'b0, last = 1'b0, err = 1'b0, own = 1'b0;
    logic [7:0]  rxd = 8'h00;
    logic [9:0]  adr;
    logic [15:0] dat;
    logic        we, done, lost;

    rx_frame_writer #(.MAXB(MAXB), .MINB(MINB)) dut (
        .eth_clk_i  (clk),
        .eth_rst_n_i(rst_n),
        .rxd_vld_i  (vld),
        .rxd_i      (rxd),
        .rxd_last_i (last),
        .rxd_err_i  (err),
        .own_i      (own),
        .eth_adr_o  (adr),
        .eth_dat_o  (dat),
        .eth_we_o   (we),
        .done_o     (done),
        .lost_o     (lost)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Buffer image as written by the DUT; stamp tells which frame wrote each word.
    logic [15:0] mem   [0:1023];
    int          stamp [0:1023];
    int          frame_id = 0;
    int          wr_total = 0;
    int          lost_total = 0;
    logic [7:0]  fb [0:2047];

    always @(negedge clk) begin
        if (we) begin
            mem[adr]   <= dat;
            stamp[adr] <= frame_id;
            wr_total   <= wr_total + 1;
        end
        if (lost) lost_total <= lost_total + 1;
    end

    typedef struct {
        int len;
        int base;
        int step;
        int err_at;
        int hdr;
        int w1;
        int lw;
        int ladr;
    } vec_t;

    vec_t vt [9];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_pattern(input int len, input int base, input int step);
        for (int k = 0; k < len; k++) fb[k] = 8'(base + k * step);
    endtask

    task automatic send_frame(input int len, input int err_at, input int own_drop_at);
        for (int k = 0; k < len; k++) begin
            if (k == own_drop_at) own = 1'b0;
            vld  = 1'b1;
            rxd  = fb[k];
            last = (k == len - 1);
            err  = (k == err_at);
            tick();
        end
        vld = 1'b0; last = 1'b0; err = 1'b0;
    endtask

    // Reference: the buffer image and header a frame of len bytes must leave behind.
    task automatic check_stored(input int len, input int err_at);
        int stored, nwords, bad, above, hdr_act;
        logic [15:0] mhdr, w;
        stored = (len < MAXB) ? len : MAXB;
        nwords = (stored + 1) / 2;
        mhdr = 16'(stored);
        if (err_at >= 0 && err_at < len) mhdr = mhdr | 16'h8000;
        if (len > MAXB)                  mhdr = mhdr | 16'h4000;
        if (stored < MINB)               mhdr = mhdr | 16'h2000;
        bad = 0;
        for (int i = 0; i < nwords; i++) begin
            w[7:0]  = fb[2 * i];
            w[15:8] = (2 * i + 1 < stored) ? fb[2 * i + 1] : 8'h00;
            if (stamp[i + 1] != frame_id || mem[i + 1] != w) bad++;
        end
        chk("data_words_bad", bad, 0);
        above = 0;
        for (int a = nwords + 1; a < 1024; a++) if (stamp[a] == frame_id) above++;
        chk("writes_above_end", above, 0);
        hdr_act = (stamp[0] == frame_id) ? int'(mem[0]) : -1;
        chk("header_model", hdr_act, int'(mhdr));
    endtask

    task automatic run_frame(input int len, input int err_at, input bit release_own);
        int w0, l0, stored;
        frame_id++;
        own = 1'b1;
        repeat (12) tick();
        w0 = wr_total;
        l0 = lost_total;
        send_frame(len, err_at, -1);
        tick();
        chk("done_at_n2", int'(done), 0);
        tick();
        chk("done_at_n3", int'(done), 1);
        check_stored(len, err_at);
        stored = (len < MAXB) ? len : MAXB;
        chk("write_count", wr_total - w0, (stored + 1) / 2 + 1);
        chk("lost_none", lost_total - l0, 0);
        if (release_own) begin
            own = 1'b0;
            tick();
            chk("done_release", int'(done), 0);
        end
    endtask

    function automatic int highest_stamped();
        int hi;
        hi = -1;
        for (int a = 1; a < 1024; a++) if (stamp[a] == frame_id) hi = a;
        return hi;
    endfunction

    initial begin
        int w0, l0, len, ea;

        vt[0] = '{64,   'h00, 'h01, -1, 'h0040, 'h0100, 'h3F3E, 32};
        vt[1] = '{5,    'hAA, 'h11, -1, 'h2005, 'hBBAA, 'h00EE, 3};
        vt[2] = '{1600, 'h00, 'h01, -1, 'h45EE, 'h0100, 'hEDEC, 759};
        vt[3] = '{100,  'h10, 'h03, 50, 'h8064, 'h1310, 'h3936, 50};
        vt[4] = '{1,    'h5A, 'h00, -1, 'h2001, 'h005A, 'h005A, 1};
        vt[5] = '{60,   'h33, 'h07, -1, 'h003C, 'h3A33, 'hD0C9, 30};
        vt[6] = '{59,   'h00, 'h01, -1, 'h203B, 'h0100, 'h003A, 30};
        vt[7] = '{1519, 'h00, 'h01, -1, 'h45EE, 'h0100, 'hEDEC, 759};
        vt[8] = '{1518, 'h00, 'h01, -1, 'h05EE, 'h0100, 'hEDEC, 759};

        // Reset state
        tick();
        tick();
        chk("rst_adr", int'(adr), 0);
        chk("rst_dat", int'(dat), 0);
        chk("rst_we", int'(we), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_lost", int'(lost), 0);
        rst_n = 1'b1;
        tick();

        // Table vectors
        for (int i = 0; i < 9; i++) begin
            fill_pattern(vt[i].len, vt[i].base, vt[i].step);
            run_frame(vt[i].len, vt[i].err_at, 1'b1);
            chk("hdr_table", int'(mem[0]), vt[i].hdr);
            chk("word1_table", int'(mem[1]), vt[i].w1);
            chk("last_word_table", int'(mem[vt[i].ladr]), vt[i].lw);
            chk("last_adr_table", highest_stamped(), vt[i].ladr);
        end

        // Randomized frames against the reference
        for (int i = 0; i < 12; i++) begin
            len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1510, 1530))
                                              : int'($urandom_range(1, 300));
            for (int k = 0; k < len; k++) fb[k] = 8'($urandom);
            ea = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1;
            run_frame(len, ea, 1'b1);
        end

        // Ownership withdrawn at byte 30
        frame_id++;
        own = 1'b1;
        repeat (12) tick();
        w0 = wr_total;
        l0 = lost_total;
        fill_pattern(100, 'h40, 1);
        send_frame(100, -1, 30);
        repeat (6) tick();
        chk("ownloss_lost", lost_total - l0, 1);
        chk("ownloss_writes", wr_total - w0, 15);
        chk("ownloss_no_hdr", stamp[0] == frame_id ? 1 : 0, 0);
        chk("ownloss_done", int'(done), 0);

        // Frame with no buffer owned
        repeat (12) tick();
        w0 = wr_total;
        l0 = lost_total;
        fill_pattern(20, 'h01, 1);
        send_frame(20, -1, -1);
        repeat (4) tick();
        chk("noown_writes", wr_total - w0, 0);
        chk("noown_lost", lost_total - l0, 1);
        chk("noown_done", int'(done), 0);

        // Frame arriving while a completed frame awaits the firmware
        fill_pattern(64, 0, 1);
        run_frame(64, -1, 1'b0);
        repeat (12) tick();
        w0 = wr_total;
        l0 = lost_total;
        fill_pattern(10, 'h77, 1);
        send_frame(10, -1, -1);
        repeat (4) tick();
        chk("indone_writes", wr_total - w0, 0);
        chk("indone_lost", lost_total - l0, 1);
        chk("indone_done_held", int'(done), 1);
        own = 1'b0;
        tick();
        tick();
        chk("indone_release", int'(done), 0);

        // Reset in the middle of a frame, then a clean frame
        own = 1'b1;
        repeat (12) tick();
        fill_pattern(80, 'h90, 1);
        w0 = wr_total;
        l0 = lost_total;
        for (int k = 0; k < 80; k++) begin
            if (k == 20) begin
                rst_n = 1'b0;
                #1;
                chk("midrst_we", int'(we), 0);
                chk("midrst_adr", int'(adr), 0);
            end
            if (k == 21) begin
                rst_n = 1'b1;
                w0 = wr_total;
                l0 = lost_total;
            end
            vld  = 1'b1;
            rxd  = fb[k];
            last = (k == 79);
            tick();
        end
        vld = 1'b0;
        last = 1'b0;
        repeat (4) tick();
        chk("midrst_discard_writes", wr_total - w0, 0);
        chk("midrst_discard_lost", lost_total - l0, 0);
        chk("midrst_done", int'(done), 0);
        fill_pattern(64, 0, 1);
        run_frame(64, -1, 1'b1);
        chk("midrst_hdr", int'(mem[0]), 'h0040);
        chk("midrst_w32", int'(mem[32]), 'h3F3E);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
